// File: rtl/zapper_sense_if.sv
// Pixel-stream bundle between the PPU timing/colour source and the Zapper sense stage.
// The master drives the pixel stream. The slave returns the reticle overlay select.
interface zapper_sense_if;
  logic       pix_ce;
  logic [5:0] color;
  logic [8:0] count_h;
  logic [8:0] count_v;
  logic [1:0] reticle;

  modport master (
    output pix_ce,
    output color,
    output count_h,
    output count_v,
    input  reticle
  );

  modport slave (
    input  pix_ce,
    input  color,
    input  count_h,
    input  count_v,
    output reticle
  );
endinterface

// File: rtl/zapper_sense.sv
// Zapper light-gun emulation: counts bright pixels in a box around the cursor, then holds
// the light output for a number of lines. It also stretches the trigger and draws the reticle.
module zapper_sense #(
  parameter int unsigned HALF        = 2,
  parameter int unsigned THRESH      = 4,
  parameter int unsigned HOLD_LINES  = 20,
  parameter int unsigned TRIG_FRAMES = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [7:0]     cursor_x,
  input  logic [7:0]     cursor_y,
  input  logic           trigger_in,
  output logic           light,
  output logic           trigger_out,
  zapper_sense_if.slave  pix
);

  typedef enum logic [1:0] {WAIT, SENSE, LIT} state_t;

  localparam logic [3:0] THRESH_V  = 4'(THRESH);
  localparam logic [5:0] LAST_LINE = 6'(HOLD_LINES - 1);
  localparam logic [7:0] TRIG_V    = 8'(TRIG_FRAMES);
  localparam logic [9:0] HALF_V    = 10'(HALF);

  state_t     state;
  logic [3:0] hit_cnt;
  logic [5:0] line_cnt;
  logic [7:0] trig_frames;
  logic       frame_seen;
  logic       trig_s1, trig_s2, trig_s2_d;

  logic [9:0] dx, dy, adx, ady;
  logic       visible, in_box, bright, hit;
  logic       frame_start, line_end;
  logic [3:0] hit_base, hit_next;
  logic       ret_draw;

  // The signed differences are kept 10 bits wide, so a box at a screen edge is clipped, not wrapped.
  always_comb begin
    dx  = {1'b0, pix.count_h} - {2'b00, cursor_x};
    dy  = {1'b0, pix.count_v} - {2'b00, cursor_y};
    adx = dx[9] ? (10'd0 - dx) : dx;
    ady = dy[9] ? (10'd0 - dy) : dy;
  end

  always_comb begin
    visible     = (pix.count_h < 9'd256) && (pix.count_v < 9'd240);
    in_box      = visible && (adx <= HALF_V) && (ady <= HALF_V);
    bright      = ((pix.color[5:4] >= 2'd2) && (pix.color[3:0] <= 4'hC)) ||
                  (pix.color == 6'h20) || (pix.color == 6'h30);
    hit         = in_box && bright;
    frame_start = (pix.count_v == 9'd0) && (pix.count_h == 9'd0);
    line_end    = (pix.count_h == 9'd340);
  end

  // A frame-start pixel starts the new count, so a hit on that pixel counts toward the threshold.
  always_comb begin
    hit_base = frame_start ? 4'd0 : hit_cnt;
    hit_next = hit_base;
    if (hit && (hit_base != 4'd15))
      hit_next = hit_base + 4'd1;
  end

  always_comb begin
    ret_draw = enable && visible &&
               (((dx == 10'd0) && (ady <= 10'd3)) || ((dy == 10'd0) && (adx <= 10'd3)));
    pix.reticle = {ret_draw & light, ret_draw};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT;
      light       <= 1'b0;
      hit_cnt     <= '0;
      line_cnt    <= '0;
      frame_seen  <= 1'b0;
      trig_frames <= '0;
      trigger_out <= 1'b0;
      trig_s1     <= 1'b0;
      trig_s2     <= 1'b0;
      trig_s2_d   <= 1'b0;
    end else begin
      trig_s1   <= trigger_in;
      trig_s2   <= trig_s1;
      trig_s2_d <= trig_s2;

      if (trig_s2 && !trig_s2_d) begin
        trigger_out <= 1'b1;
        trig_frames <= TRIG_V;
      end else begin
        if (pix.pix_ce && frame_start && (trig_frames != 8'd0))
          trig_frames <= trig_frames - 8'd1;
        if ((trig_frames == 8'd0) && !trig_s2)
          trigger_out <= 1'b0;
      end

      if (!enable) begin
        state <= WAIT;
        light <= 1'b0;
      end else if (pix.pix_ce) begin
        unique case (state)
          WAIT, SENSE: begin
            if ((state == SENSE) || frame_start) begin
              hit_cnt <= hit_next;
              if (hit && (hit_next == THRESH_V)) begin
                state      <= LIT;
                light      <= 1'b1;
                line_cnt   <= '0;
                frame_seen <= 1'b0;
              end else begin
                state <= SENSE;
              end
            end
          end
          LIT: begin
            if (line_end && (line_cnt == LAST_LINE)) begin
              light      <= 1'b0;
              line_cnt   <= '0;
              frame_seen <= 1'b0;
              if (frame_seen || frame_start) begin
                state   <= SENSE;
                hit_cnt <= '0;
              end else begin
                state <= WAIT;
              end
            end else begin
              if (line_end)
                line_cnt <= line_cnt + 6'd1;
              if (frame_start)
                frame_seen <= 1'b1;
            end
          end
          default: state <= WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zapper_sense.sv
// Directed bench for zapper_sense. It drives sparse pixel streams and checks light, trigger and reticle.
module tb_zapper_sense;
  logic       clk = 1'b0;
  logic       reset, enable, trigger_in, light, trigger_out;
  logic [7:0] cursor_x, cursor_y;
  int         checks = 0;
  int         failures = 0;
  logic       held;

  zapper_sense_if zif();

  zapper_sense #(.HALF(2), .THRESH(4), .HOLD_LINES(20), .TRIG_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .trigger_in(trigger_in),
    .light(light), .trigger_out(trigger_out), .pix(zif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int h, input int v, input logic [5:0] c);
    @(negedge clk);
    zif.count_h = 9'(h);
    zif.count_v = 9'(v);
    zif.color   = c;
    zif.pix_ce  = 1'b1;
    @(posedge clk);
    #1;
    zif.pix_ce  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic line_ends(input int a, input int b, input logic [5:0] c);
    for (int v = a; v <= b; v++) step(340, v, c);
  endtask

  task automatic box_fill(input int x0, input int y0, input logic [5:0] c);
    for (int y = y0; y < y0 + 5; y++)
      for (int x = x0; x < x0 + 5; x++) step(x, y, c);
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic [1:0] exp);
    zif.pix_ce  = 1'b0;
    zif.count_h = 9'(h);
    zif.count_v = 9'(v);
    #1;
    chk(tag, {6'd0, zif.reticle}, {6'd0, exp});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; trigger_in = 1'b0;
    cursor_x = 8'd100; cursor_y = 8'd100;
    zif.pix_ce = 1'b0; zif.color = 6'h0F; zif.count_h = 9'd300; zif.count_v = 9'd250;
    idle(); idle();
    reset = 1'b0;
    chk("reset_light", {7'd0, light}, 8'd0);
    chk("reset_trig", {7'd0, trigger_out}, 8'd0);
    probe("reset_reticle", 100, 100, 2'b01);

    // Test 1: white frame with the cursor at (100,100)
    step(0, 0, 6'h30);
    line_ends(0, 97, 6'h30);
    for (int x = 96; x <= 100; x++) step(x, 98, 6'h30);
    chk("t1_before_thresh", {7'd0, light}, 8'd0);
    step(101, 98, 6'h30);
    chk("t1_light_rise", {7'd0, light}, 8'd1);
    probe("t1_reticle_hl", 100, 98, 2'b11);
    line_ends(98, 116, 6'h30);
    chk("t1_light_held", {7'd0, light}, 8'd1);
    step(340, 117, 6'h30);
    chk("t1_light_fall", {7'd0, light}, 8'd0);
    for (int i = 0; i < 5; i++) step(100, 100, 6'h30);
    chk("t1_wait_no_relight", {7'd0, light}, 8'd0);

    // Test 2: colours that are not bright
    step(0, 0, 6'h0F);
    box_fill(98, 98, 6'h0F);
    chk("t2_0F_dark", {7'd0, light}, 8'd0);
    box_fill(98, 98, 6'h16);
    chk("t2_16_dark", {7'd0, light}, 8'd0);
    box_fill(98, 98, 6'h3D);
    chk("t2_3D_dark", {7'd0, light}, 8'd0);
    probe("t2_ret_center", 100, 100, 2'b01);
    probe("t2_ret_dx3", 103, 100, 2'b01);
    probe("t2_ret_dx4", 104, 100, 2'b00);
    probe("t2_ret_diag", 101, 101, 2'b00);
    probe("t2_ret_dym3", 100, 97, 2'b01);
    probe("t2_ret_dym4", 100, 96, 2'b00);

    // Test 3: cursor in the corner, so the box is clipped
    cursor_x = 8'd0; cursor_y = 8'd0;
    step(0, 0, 6'h20);
    step(1, 0, 6'h20);
    step(2, 0, 6'h20);
    chk("t3_three_hits", {7'd0, light}, 8'd0);
    step(3, 0, 6'h20);
    step(340, 0, 6'h20);
    step(0, 1, 6'h20);
    chk("t3_fourth_hit", {7'd0, light}, 8'd1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("t3_reset_in_lit", {7'd0, light}, 8'd0);

    // Test 4: light held across a frame start (the bench uses 245-line frames)
    cursor_x = 8'd128; cursor_y = 8'd235;
    step(0, 0, 6'h0F);
    line_ends(0, 232, 6'h0F);
    for (int x = 126; x <= 129; x++) step(x, 233, 6'h30);
    chk("t4_light_rise", {7'd0, light}, 8'd1);
    line_ends(233, 244, 6'h30);
    step(0, 0, 6'h0F);
    line_ends(0, 6, 6'h0F);
    chk("t4_held_over_frame", {7'd0, light}, 8'd1);
    step(340, 7, 6'h0F);
    chk("t4_expire", {7'd0, light}, 8'd0);
    line_ends(8, 232, 6'h0F);
    for (int x = 126; x <= 128; x++) step(x, 233, 6'h30);
    chk("t4_resense_3hits", {7'd0, light}, 8'd0);
    step(129, 233, 6'h30);
    chk("t4_resense_lit", {7'd0, light}, 8'd1);

    // Test 5: trigger pulse, then trigger held for 10 frames
    @(negedge clk) trigger_in = 1'b1;
    @(negedge clk) trigger_in = 1'b0;
    idle();
    chk("t5_trig_2clk", {7'd0, trigger_out}, 8'd0);
    idle();
    chk("t5_trig_3clk", {7'd0, trigger_out}, 8'd1);
    step(0, 0, 6'h0F);
    step(0, 0, 6'h0F);
    chk("t5_trig_2frames", {7'd0, trigger_out}, 8'd1);
    step(0, 0, 6'h0F);
    chk("t5_trig_3rd_frame", {7'd0, trigger_out}, 8'd1);
    idle();
    chk("t5_trig_cleared", {7'd0, trigger_out}, 8'd0);
    @(negedge clk) trigger_in = 1'b1;
    idle(); idle(); idle();
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 6'h0F);
      held = held & trigger_out;
    end
    chk("t5_trig_hold", {7'd0, held}, 8'd1);
    @(negedge clk) trigger_in = 1'b0;
    idle(); idle();
    chk("t5_release_2clk", {7'd0, trigger_out}, 8'd1);
    idle();
    chk("t5_release_3clk", {7'd0, trigger_out}, 8'd0);

    // Test 6: enable dropped while light is lit (no line ends since test 4, so still lit)
    chk("t6_still_lit", {7'd0, light}, 8'd1);
    @(negedge clk) enable = 1'b0;
    idle();
    chk("t6_disable_light", {7'd0, light}, 8'd0);
    probe("t6_disable_reticle", 128, 235, 2'b00);
    @(negedge clk) enable = 1'b1;
    for (int x = 126; x <= 130; x++) step(x, 234, 6'h30);
    chk("t6_wait_frame", {7'd0, light}, 8'd0);
    step(0, 0, 6'h0F);
    for (int x = 126; x <= 129; x++) step(x, 233, 6'h30);
    chk("t6_relit", {7'd0, light}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
